// File: rtl/rtc_menu_ctrl.sv
// RTC menu/scan controller: refreshes a window of RTC registers, then idles while
// turning debounced button edges into pointer moves, inc/dec writes and alarm acks.
module rtc_menu_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned FIRST_ADDR  = 1,
    parameter int unsigned LAST_ADDR   = 7,
    parameter int unsigned PTR_MIN     = 1,
    parameter int unsigned PTR_MAX     = 6,
    parameter int unsigned WAIT_CYCLES = 100,
    parameter int unsigned WAIT_W      = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FRW,
    input  logic              IRQ,
    input  logic              Barriba,
    input  logic              Babajo,
    input  logic              Bderecha,
    input  logic              Bizquierda,
    input  logic              Bcentro,
    output logic [ADDR_W-1:0] DIR,
    output logic              Acceso,
    output logic              Mod,
    output logic              Numup,
    output logic              Numdown,
    output logic [ADDR_W-1:0] Punt,
    output logic              Alarma
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_SCAN  = 3'd1,
        S_WAIT  = 3'd2,
        S_ACT   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        EV_CENTRE = 3'd0,
        EV_UP     = 3'd1,
        EV_DOWN   = 3'd2,
        EV_LEFT   = 3'd3,
        EV_RIGHT  = 3'd4
    } event_t;

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] PMIN  = ADDR_W'(PTR_MIN);
    localparam logic [ADDR_W-1:0] PMAX  = ADDR_W'(PTR_MAX);
    localparam logic [WAIT_W-1:0] CNT_LAST = WAIT_W'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    event_t              pendKind_q, pendKind_d;
    logic                pendValid_q, pendValid_d;
    logic [ADDR_W-1:0]   dir_q, dir_d, punt_q, punt_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                acceso_q, acceso_d, mod_q, mod_d;
    logic                numup_q, numup_d, numdown_q, numdown_d;
    logic                alarma_q, alarma_d;
    logic [4:0]          btnPrev_q, btnLevel, btnEdge;
    logic                irqPrev_q;

    // Button order doubles as the edge priority: centre > up > down > left > right.
    assign btnLevel = {Bcentro, Barriba, Babajo, Bizquierda, Bderecha};
    assign btnEdge  = btnLevel & ~btnPrev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_INIT;
            pendKind_q  <= EV_CENTRE;
            pendValid_q <= 1'b0;
            dir_q       <= FIRST;
            punt_q      <= PMIN;
            cnt_q       <= '0;
            acceso_q    <= 1'b0;
            mod_q       <= 1'b0;
            numup_q     <= 1'b0;
            numdown_q   <= 1'b0;
            alarma_q    <= 1'b0;
            btnPrev_q   <= '0;
            irqPrev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pendKind_q  <= pendKind_d;
            pendValid_q <= pendValid_d;
            dir_q       <= dir_d;
            punt_q      <= punt_d;
            cnt_q       <= cnt_d;
            acceso_q    <= acceso_d;
            mod_q       <= mod_d;
            numup_q     <= numup_d;
            numdown_q   <= numdown_d;
            alarma_q    <= alarma_d;
            btnPrev_q   <= btnLevel;
            irqPrev_q   <= IRQ;
        end
    end

    always_comb begin
        state_d     = state_q;
        pendKind_d  = pendKind_q;
        pendValid_d = pendValid_q;
        dir_d       = dir_q;
        punt_d      = punt_q;
        cnt_d       = cnt_q;
        numup_d     = numup_q;
        numdown_d   = numdown_q;
        alarma_d    = alarma_q;

        case (state_q)
            S_INIT: begin
                dir_d     = FIRST;
                numup_d   = 1'b0;
                numdown_d = 1'b0;
                if (FRW) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (FRW) begin
                    if (dir_q == LAST) begin
                        dir_d   = FIRST;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        dir_d = dir_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (pendValid_q)            state_d = S_ACT;
                else if (cnt_q == CNT_LAST) state_d = S_SCAN;
            end
            S_ACT: begin
                pendValid_d = 1'b0;
                state_d     = S_SCAN;
                // A pending alarm swallows whatever event comes next.
                if (alarma_q) begin
                    alarma_d = 1'b0;
                end else begin
                    case (pendKind_q)
                        EV_CENTRE: punt_d = PMIN;
                        EV_LEFT:   punt_d = (punt_q == PMAX) ? PMIN : punt_q + 1'b1;
                        EV_RIGHT:  punt_d = (punt_q == PMIN) ? PMAX : punt_q - 1'b1;
                        EV_UP: begin
                            state_d = S_WRITE;
                            dir_d   = punt_q;
                            numup_d = 1'b1;
                        end
                        EV_DOWN: begin
                            state_d   = S_WRITE;
                            dir_d     = punt_q;
                            numdown_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                if (FRW) begin
                    numup_d   = 1'b0;
                    numdown_d = 1'b0;
                    dir_d     = FIRST;
                    state_d   = S_SCAN;
                end
            end
            default: begin
                state_d   = S_INIT;
                dir_d     = FIRST;
                numup_d   = 1'b0;
                numdown_d = 1'b0;
            end
        endcase

        if (!pendValid_q && (btnEdge != 5'b0)) begin
            pendValid_d = 1'b1;
            if      (btnEdge[4]) pendKind_d = EV_CENTRE;
            else if (btnEdge[3]) pendKind_d = EV_UP;
            else if (btnEdge[2]) pendKind_d = EV_DOWN;
            else if (btnEdge[1]) pendKind_d = EV_LEFT;
            else                 pendKind_d = EV_RIGHT;
        end

        if (IRQ && !irqPrev_q) alarma_d = 1'b1;

        acceso_d = (state_d == S_SCAN) || (state_d == S_WRITE);
        mod_d    = (state_d == S_WRITE);
    end

    assign DIR     = dir_q;
    assign Acceso  = acceso_q;
    assign Mod     = mod_q;
    assign Numup   = numup_q;
    assign Numdown = numdown_q;
    assign Punt    = punt_q;
    assign Alarma  = alarma_q;

endmodule

// File: tb/tb_rtc_menu_ctrl.sv
// Directed bench for rtc_menu_ctrl: scan timing, pointer wrap, writes, alarm handling,
// button priority and asynchronous reset during a write.
module tb_rtc_menu_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       FRW = 1'b0;
    logic       IRQ = 1'b0;
    logic       Barriba = 1'b0, Babajo = 1'b0, Bderecha = 1'b0, Bizquierda = 1'b0, Bcentro = 1'b0;
    logic [2:0] DIR, Punt;
    logic       Acceso, Mod, Numup, Numdown, Alarma;
    logic [4:0] flags;

    int nCompared   = 0;
    int nMismatched = 0;

    // Button masks in {centre, up, down, left, right} order.
    localparam logic [4:0] BTN_C = 5'b10000, BTN_U = 5'b01000, BTN_D = 5'b00100;
    localparam logic [4:0] BTN_L = 5'b00010, BTN_R = 5'b00001;
    // Output flags in {Acceso, Mod, Numup, Numdown, Alarma} order.
    localparam logic [4:0] F_IDLE = 5'b00000, F_SCAN = 5'b10000, F_SCAN_AL = 5'b10001;
    localparam logic [4:0] F_WR_UP = 5'b11100, F_WR_DN = 5'b11010;

    assign flags = {Acceso, Mod, Numup, Numdown, Alarma};

    rtc_menu_ctrl dut (
        .CLK(CLK), .RST(RST), .FRW(FRW), .IRQ(IRQ),
        .Barriba(Barriba), .Babajo(Babajo), .Bderecha(Bderecha),
        .Bizquierda(Bizquierda), .Bcentro(Bcentro),
        .DIR(DIR), .Acceso(Acceso), .Mod(Mod), .Numup(Numup), .Numdown(Numdown),
        .Punt(Punt), .Alarma(Alarma)
    );

    always #5 CLK = ~CLK;

    task automatic setBtns(input logic [4:0] v);
        {Bcentro, Barriba, Babajo, Bizquierda, Bderecha} = v;
    endtask

    task automatic pulseFrw();
        FRW = 1'b1;
        @(negedge CLK);
        FRW = 1'b0;
    endtask

    // From SCAN at DIR=1, run the whole window; ends in the first WAIT cycle.
    task automatic runScan();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge CLK);
            pulseFrw();
        end
    endtask

    // Scan, then press buttons in the first WAIT cycle; ends one cycle after ACT.
    task automatic applyStimulus(input logic [4:0] v);
        runScan();
        setBtns(v);
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        nCompared++; if (flags !== F_IDLE) begin nMismatched++; $display("[TB] FAIL reset_flags: got %b expected %b", flags, F_IDLE); end
        nCompared++; if (DIR !== 3'd1) begin nMismatched++; $display("[TB] FAIL reset_dir: got %0d expected 1", DIR); end
        nCompared++; if (Punt !== 3'd1) begin nMismatched++; $display("[TB] FAIL reset_punt: got %0d expected 1", Punt); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        nCompared++; if (flags !== F_IDLE) begin nMismatched++; $display("[TB] FAIL init_idle: got %b expected %b", flags, F_IDLE); end
    endtask

    task automatic test_scan();
        int n;
        pulseFrw();
        for (int i = 1; i <= 7; i++) begin
            repeat (2) @(negedge CLK);
            nCompared++; if (DIR !== 3'(i)) begin nMismatched++; $display("[TB] FAIL scan_dir: got %0d expected %0d", DIR, i); end
            nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL scan_flags: got %b expected %b", flags, F_SCAN); end
            pulseFrw();
        end
        nCompared++; if (DIR !== 3'd1) begin nMismatched++; $display("[TB] FAIL scan_wrap_dir: got %0d expected 1", DIR); end
        n = 0;
        while (Acceso === 1'b0 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        nCompared++; if (n !== 100) begin nMismatched++; $display("[TB] FAIL wait_len: got %0d expected 100", n); end
        nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL rescan_flags: got %b expected %b", flags, F_SCAN); end
    endtask

    task automatic test_pointer();
        logic [4:0] btn [4] = '{BTN_R, BTN_L, BTN_L, BTN_L};
        logic [2:0] exp [4] = '{3'd6, 3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(btn[i]);
            nCompared++; if (Punt !== exp[i]) begin nMismatched++; $display("[TB] FAIL ptr_move%0d: got %0d expected %0d", i, Punt, exp[i]); end
            nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL ptr_flags%0d: got %b expected %b", i, flags, F_SCAN); end
            setBtns(5'b0);
        end
    endtask

    task automatic test_write();
        applyStimulus(BTN_U);
        nCompared++; if (DIR !== 3'd3) begin nMismatched++; $display("[TB] FAIL wr_dir: got %0d expected 3", DIR); end
        nCompared++; if (flags !== F_WR_UP) begin nMismatched++; $display("[TB] FAIL wr_flags: got %b expected %b", flags, F_WR_UP); end
        repeat (4) @(negedge CLK);
        nCompared++; if (flags !== F_WR_UP) begin nMismatched++; $display("[TB] FAIL wr_hold: got %b expected %b", flags, F_WR_UP); end
        setBtns(5'b0);
        pulseFrw();
        nCompared++; if (DIR !== 3'd1) begin nMismatched++; $display("[TB] FAIL wr_done_dir: got %0d expected 1", DIR); end
        nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL wr_done_flags: got %b expected %b", flags, F_SCAN); end
    endtask

    task automatic test_alarm();
        IRQ = 1'b1;
        @(negedge CLK);
        nCompared++; if (flags !== F_SCAN_AL) begin nMismatched++; $display("[TB] FAIL al_set: got %b expected %b", flags, F_SCAN_AL); end
        applyStimulus(BTN_D);
        nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL al_ack: got %b expected %b", flags, F_SCAN); end
        nCompared++; if (Punt !== 3'd3) begin nMismatched++; $display("[TB] FAIL al_ack_punt: got %0d expected 3", Punt); end
        setBtns(5'b0);
        applyStimulus(BTN_D);
        nCompared++; if (flags !== F_WR_DN) begin nMismatched++; $display("[TB] FAIL al_down_wr: got %b expected %b", flags, F_WR_DN); end
        nCompared++; if (DIR !== 3'd3) begin nMismatched++; $display("[TB] FAIL al_down_dir: got %0d expected 3", DIR); end
        setBtns(5'b0);
        pulseFrw();
        nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL al_down_done: got %b expected %b", flags, F_SCAN); end
        // A new IRQ edge landing on the acknowledge cycle must keep the alarm.
        IRQ = 1'b0;
        @(negedge CLK);
        IRQ = 1'b1;
        @(negedge CLK);
        IRQ = 1'b0;
        runScan();
        setBtns(BTN_R);
        repeat (2) @(negedge CLK);
        IRQ = 1'b1;
        @(negedge CLK);
        nCompared++; if (flags !== F_SCAN_AL) begin nMismatched++; $display("[TB] FAIL al_reassert: got %b expected %b", flags, F_SCAN_AL); end
        nCompared++; if (Punt !== 3'd3) begin nMismatched++; $display("[TB] FAIL al_reassert_punt: got %0d expected 3", Punt); end
        setBtns(5'b0);
        IRQ = 1'b0;
        applyStimulus(BTN_R);
        nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL al_ack2: got %b expected %b", flags, F_SCAN); end
        nCompared++; if (Punt !== 3'd3) begin nMismatched++; $display("[TB] FAIL al_ack2_punt: got %0d expected 3", Punt); end
        setBtns(5'b0);
    endtask

    task automatic test_centre();
        int n;
        applyStimulus(BTN_C | BTN_U);
        nCompared++; if (Punt !== 3'd1) begin nMismatched++; $display("[TB] FAIL ctr_punt: got %0d expected 1", Punt); end
        nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL ctr_flags: got %b expected %b", flags, F_SCAN); end
        applyStimulus(BTN_C | BTN_U);
        nCompared++; if (flags !== F_IDLE) begin nMismatched++; $display("[TB] FAIL held_no_event: got %b expected %b", flags, F_IDLE); end
        n = 0;
        while (Acceso === 1'b0 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        nCompared++; if (n !== 97) begin nMismatched++; $display("[TB] FAIL held_wait_len: got %0d expected 97", n); end
        nCompared++; if (flags !== F_SCAN) begin nMismatched++; $display("[TB] FAIL held_rescan: got %b expected %b", flags, F_SCAN); end
        setBtns(5'b0);
    endtask

    task automatic test_reset_mid_write();
        applyStimulus(BTN_L);
        setBtns(5'b0);
        applyStimulus(BTN_U);
        setBtns(5'b0);
        nCompared++; if (flags !== F_WR_UP || DIR !== 3'd2) begin nMismatched++; $display("[TB] FAIL rw_pre: got %b/%0d expected %b/2", flags, DIR, F_WR_UP); end
        #2 RST = 1'b1;
        #1;
        nCompared++; if (flags !== F_IDLE) begin nMismatched++; $display("[TB] FAIL rw_flags: got %b expected %b", flags, F_IDLE); end
        nCompared++; if (DIR !== 3'd1 || Punt !== 3'd1) begin nMismatched++; $display("[TB] FAIL rw_regs: got %0d/%0d expected 1/1", DIR, Punt); end
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        nCompared++; if (flags !== F_IDLE) begin nMismatched++; $display("[TB] FAIL rw_init: got %b expected %b", flags, F_IDLE); end
        pulseFrw();
        nCompared++; if (flags !== F_SCAN || DIR !== 3'd1) begin nMismatched++; $display("[TB] FAIL rw_scan: got %b/%0d expected %b/1", flags, DIR, F_SCAN); end
    endtask

    initial begin
        $display("[TB] rtc_menu_ctrl directed test start");
        test_reset();
        test_scan();
        test_pointer();
        test_write();
        test_alarm();
        test_centre();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/rtc_menu_ctrl.md
Name: rtc_menu_ctrl

Overview:
Parametrised menu/scan controller for the RTC interface. It repeatedly refreshes a configurable window of RTC registers through the RTC access controller, then idles for a programmable wait period. During the wait it services debounced user buttons: it moves the edit pointer, requests increment/decrement writes, and acknowledges the RTC alarm interrupt. It sits between the button debouncers and the RTC read/write controller.

Parameters:
ADDR_W, 3, width of DIR and Punt
FIRST_ADDR, 1, first RTC register in the scan window
LAST_ADDR, 7, last RTC register in the scan window (must be >= FIRST_ADDR)
PTR_MIN, 1, lowest editable address
PTR_MAX, 6, highest editable address (must be >= PTR_MIN)
WAIT_CYCLES, 100, idle cycles between scans (>= 1)
WAIT_W, 9, wait-counter width (2^WAIT_W > WAIT_CYCLES)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
FRW  in  1  one-cycle pulse: RTC controller finished the current read/write
IRQ  in  1  RTC alarm interrupt, level
Barriba  in  1  up button, debounced level
Babajo  in  1  down button, debounced level
Bderecha  in  1  right button, debounced level
Bizquierda  in  1  left button, debounced level
Bcentro  in  1  centre button, debounced level
DIR  out  ADDR_W  RTC register address for the current access
Acceso  out  1  request/hold RTC access
Mod  out  1  current access is a write (modify)
Numup  out  1  write increments register at DIR
Numdown  out  1  write decrements register at DIR
Punt  out  ADDR_W  edit pointer
Alarma  out  1  alarm active, awaiting user acknowledge

Behaviour:
- Reset (async, any state): state=INIT, DIR=FIRST_ADDR, Punt=PTR_MIN, Acceso=Mod=Numup=Numdown=Alarma=0, wait counter=0, pending event cleared, edge registers=0. All outputs are registered.
- Button edges: each button has a prev-level register. event = level & ~prev. Events are latched into a one-deep pending register in any state. Edges arriving while an event is pending are dropped. Simultaneous edges resolve to one event with priority centre > up > down > left > right.
- IRQ: a rising edge sets Alarma=1. While Alarma=1, the next processed event of any type only clears Alarma and is consumed. An IRQ edge in the same cycle as that clear leaves Alarma=1.
- INIT: Acceso=0. FRW pulse -> SCAN (RTC init done).
- SCAN: Acceso=1, Mod=0, DIR held stable.
  - On FRW with DIR!=LAST_ADDR: DIR<=DIR+1, stay in SCAN.
  - On FRW with DIR==LAST_ADDR: DIR<=FIRST_ADDR, counter<=0, go to WAIT.
- WAIT: Acceso=0, counter increments each cycle.
  - If an event is pending: go to ACT next cycle (early exit).
  - Otherwise, when counter==WAIT_CYCLES-1: go to SCAN.
  - Net effect: WAIT lasts exactly WAIT_CYCLES cycles when no event occurs.
- ACT (1 cycle): consumes the pending event.
  - Alarm acknowledge or centre: Punt<=PTR_MIN (centre only), then go to SCAN.
  - Left: Punt<=Punt+1, wrapping from PTR_MAX to PTR_MIN; then SCAN.
  - Right: Punt<=Punt-1, wrapping from PTR_MIN to PTR_MAX; then SCAN.
  - Up/down: go to WRITE.
- WRITE: Acceso=1, Mod=1, DIR=Punt, and Numup or Numdown held at 1 for the whole state.
  - On FRW: clear Mod/Numup/Numdown, DIR<=FIRST_ADDR, go to SCAN (full refresh).
- FRW in INIT-excluded states other than SCAN/WRITE (WAIT, ACT) is ignored.
- Numup and Numdown are never both 1. Mod=1 only in WRITE.
- Address arithmetic is ADDR_W bits, unsigned. Wrap is explicit at the PTR bounds, never modulo 2^ADDR_W.
- Illegal state encoding -> INIT.

Test Plan:
- Reset, then FRW pulse, then 7 FRW pulses spaced 3 cycles apart -> DIR steps 1..7 with Acceso=1, returns to DIR=1; Acceso=0 for exactly 100 cycles, then SCAN restarts.
- Pulse Bizquierda during WAIT with Punt=6 -> Punt=1 (wrap); Bderecha with Punt=1 -> Punt=6; no Mod asserted; SCAN restarts early.
- Barriba during WAIT with Punt=3 -> WRITE: DIR=3, Mod=1, Numup=1 until FRW; then DIR=1, SCAN, Mod=0.
- IRQ rising edge -> Alarma=1; press Babajo -> Alarma=0, no write issued, Punt unchanged; the next Babajo issues a Numdown write.
- Bcentro and Barriba rising in the same cycle -> only centre processed (Punt=PTR_MIN), no write; held buttons produce no repeat events.
- Assert RST mid-WRITE -> all outputs return to reset values immediately; the next FRW goes INIT -> SCAN.
